// File: rtl/alu_sequencer.sv
// ALU sequencer: IDLE -> EXEC (1/MUL_CYCLES/DIV_CYCLES) -> WRITE.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN enables the illegal-opcode err pulse.
module alu_sequencer #(
    parameter int MUL_CYCLES = 16,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    output logic [12:0] op_sel,
    output logic [4:0]  step,
    output logic        Zlow_in,
    output logic        Zhigh_in,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

    logic [1:0]  state;
    logic [4:0]  op_q;
    logic [4:0]  step_q;
    logic [12:0] dec_in;
    logic [12:0] dec_q;
    logic [4:0]  last;
    logic        legal;

    function automatic logic [12:0] decode(input logic [4:0] op);
        logic [12:0] d;
        d = '0;
        case (op)
            5'b00011: d[0]  = 1'b1;
            5'b00100: d[1]  = 1'b1;
            5'b01111: d[2]  = 1'b1;
            5'b10000: d[3]  = 1'b1;
            5'b01010: d[4]  = 1'b1;
            5'b01011: d[5]  = 1'b1;
            5'b00101: d[6]  = 1'b1;
            5'b00110: d[7]  = 1'b1;
            5'b00111: d[8]  = 1'b1;
            5'b01000: d[9]  = 1'b1;
            5'b01001: d[10] = 1'b1;
            5'b10001: d[11] = 1'b1;
            5'b10010: d[12] = 1'b1;
            default:  d     = '0;
        endcase
        return d;
    endfunction

    // Decode incoming and latched opcodes; pick the final EXEC step index.
    always_comb begin
        dec_in = decode(opcode);
        dec_q  = decode(op_q);
        legal  = |dec_in;
        last   = '0;
        if (dec_q[2])
            last = MUL_LAST;
        else if (dec_q[3])
            last = DIV_LAST;
    end

    // Main FSM: accept in IDLE, count EXEC steps, single WRITE cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= S_IDLE;
            op_q   <= '0;
            step_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    step_q <= '0;
                    if (start && legal) begin
                        op_q  <= opcode;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (step_q == last)
                        state <= S_WRITE;
                    else
                        step_q <= step_q + 5'd1;
                end
                S_WRITE: begin
                    state  <= S_IDLE;
                    step_q <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    step_q <= '0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic err_q;

    // One-cycle err pulse after an illegal request seen in IDLE.
    always_ff @(posedge clock) begin
        if (clear)
            err_q <= 1'b0;
        else
            err_q <= (state == S_IDLE) && start && !legal;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy     = (state != S_IDLE);
    assign op_sel   = busy ? dec_q : 13'd0;
    assign step     = step_q;
    assign done     = (state == S_WRITE);
    assign Zlow_in  = done;
    assign Zhigh_in = done && (dec_q[2] || dec_q[3]);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer.
// Per-cycle schedule model plus directed literal checks.
module tb_alu_sequencer;

    localparam int MUL_N = 16;
    localparam int DIV_N = 32;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, SHR = 5'b00101,
        SHRA = 5'b00110, SHL = 5'b00111, ROR = 5'b01000, ROL = 5'b01001,
        AND_ = 5'b01010, OR_ = 5'b01011, MUL = 5'b01111, DIV = 5'b10000,
        NEG = 5'b10001, NOT_ = 5'b10010;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [12:0] op_sel;
    logic [4:0]  step;
    logic        Zlow_in, Zhigh_in, busy, done, err;

    int tests = 0;
    int failed = 0;
    bit armed = 1'b0;

    alu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .op_sel(op_sel), .step(step), .Zlow_in(Zlow_in),
        .Zhigh_in(Zhigh_in), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [12:0] op_sel;
        logic [4:0]  step;
        logic        zl;
        logic        zh;
        logic        busy;
        logic        done;
    } rec_t;

    rec_t q[$];
    bit   exp_err = 1'b0;

    function automatic int op_index(input logic [4:0] op);
        case (op)
            ADD: return 0;   SUB: return 1;   MUL: return 2;
            DIV: return 3;   AND_: return 4;  OR_: return 5;
            SHR: return 6;   SHRA: return 7;  SHL: return 8;
            ROR: return 9;   ROL: return 10;  NEG: return 11;
            NOT_: return 12;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted op expands into its per-cycle output schedule.
    always @(posedge clock) begin : model
        bit   was_idle;
        int   idx;
        int   n;
        rec_t r;
        was_idle = (q.size() == 0);
        if (!was_idle)
            void'(q.pop_front());
        exp_err = 1'b0;
        if (clear) begin
            q.delete();
        end else if (was_idle && start) begin
            idx = op_index(opcode);
            if (idx < 0) begin
                exp_err = TRAP;
            end else begin
                n = (idx == 2) ? MUL_N : (idx == 3) ? DIV_N : 1;
                for (int k = 0; k < n; k++) begin
                    r = '0;
                    r.op_sel = 13'd1 << idx;
                    r.step = 5'(k);
                    r.busy = 1'b1;
                    q.push_back(r);
                end
                r = '0;
                r.op_sel = 13'd1 << idx;
                r.step = 5'(n - 1);
                r.zl = 1'b1;
                r.zh = (idx == 2) || (idx == 3);
                r.busy = 1'b1;
                r.done = 1'b1;
                q.push_back(r);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin : compare
        rec_t e;
        if (armed) begin
            e = (q.size() > 0) ? q[0] : '0;
            chk("model", {9'd0, op_sel, step, Zlow_in, Zhigh_in, busy, done, err},
                {9'd0, e.op_sel, e.step, e.zl, e.zh, e.busy, e.done, exp_err});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [4:0]  ops   [13] = '{ADD, SUB, MUL, DIV, AND_, OR_, SHR, SHRA,
                                 SHL, ROR, ROL, NEG, NOT_};
    logic [12:0] sels  [13] = '{13'h001, 13'h002, 13'h004, 13'h008, 13'h010,
                                13'h020, 13'h040, 13'h080, 13'h100, 13'h200,
                                13'h400, 13'h800, 13'h1000};

    initial begin
        int waited;
        tick(2);
        armed = 1'b1;
        chk("reset_vals", {op_sel, step, Zlow_in, Zhigh_in, busy, done, err}, 0);
        clear = 1'b0;
        tick(1);

        // AND
        start = 1'b1; opcode = AND_;
        tick(1); start = 1'b0;
        chk("and_c1_opsel", op_sel, 13'h010);
        tick(1);
        chk("and_c2_opsel", op_sel, 13'h010);
        chk("and_c2_done", {done, Zlow_in, Zhigh_in}, 3'b110);
        tick(1);
        chk("and_c3_busy", busy, 0);

        // MUL with default cycle count
        start = 1'b1; opcode = MUL;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 1) start = 1'b0;
            chk("mul_step", {busy, done, step}, {2'b10, 5'(k - 1)});
        end
        tick(1);
        chk("mul_c17", {done, Zlow_in, Zhigh_in, step}, {3'b111, 5'd15});
        tick(1);
        chk("mul_c18_busy", busy, 0);

        // DIV aborted by clear in cycle 10
        start = 1'b1; opcode = DIV;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (k == 1) start = 1'b0;
            if (k == 10) clear = 1'b1;
        end
        tick(1);
        clear = 1'b0;
        chk("div_abort", {busy, done, Zlow_in, Zhigh_in, step}, 0);
        start = 1'b1; opcode = ADD;
        tick(1); start = 1'b0;
        chk("add_after_abort_c1", op_sel, 13'h001);
        tick(1);
        chk("add_after_abort_c2", {done, Zlow_in, Zhigh_in}, 3'b110);
        tick(1);

        // start held through DIV, opcode switched to ADD
        start = 1'b1; opcode = DIV;
        for (int k = 1; k <= 32; k++) begin
            tick(1);
            if (k == 1) opcode = ADD;
            chk("div_hold_opsel", op_sel, 13'h008);
        end
        tick(1);
        chk("div_c33", {done, Zlow_in, Zhigh_in, step}, {3'b111, 5'd31});
        tick(1);
        chk("div_c34_idle", busy, 0);
        tick(1);
        chk("add_c35", {busy, op_sel}, {1'b1, 13'h001});
        start = 1'b0;
        tick(2);

        // illegal opcode
        start = 1'b1; opcode = 5'b11111;
        tick(1); start = 1'b0;
        chk("illegal_c1", {err, busy, op_sel}, {TRAP, 1'b0, 13'h000});
        tick(1);
        chk("illegal_c2", {err, busy}, 0);

        // back-to-back SUB with start held
        start = 1'b1; opcode = SUB;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            if (c == 9) start = 1'b0;
            chk("b2b_done", done, (c % 3 == 2));
        end
        tick(1);

        // every legal opcode
        for (int i = 0; i < 13; i++) begin
            start = 1'b1; opcode = ops[i];
            tick(1); start = 1'b0;
            chk("op_table", op_sel, sels[i]);
            waited = 0;
            while (busy && waited < 40) begin
                tick(1);
                waited++;
            end
            if (busy) chk("op_table_timeout", busy, 0);
        end

        // clear wins over simultaneous start
        clear = 1'b1; start = 1'b1; opcode = ADD;
        tick(1);
        clear = 1'b0; start = 1'b0;
        chk("clear_prio", {busy, op_sel}, 0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
